// File: rtl/seq_ctrl_pkg.sv
// Shared types and opcode constants for the accumulator CPU sequencer.
// The instruction word is {op[5:0], field[AW-1:0]}.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_OPER   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_STORE  = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_STORE = 6'b101000;
    localparam logic [5:0] OP_NOP   = 6'b101001;
    localparam logic [5:0] OP_JMPA  = 6'b101100;
    localparam logic [5:0] OP_JMP   = 6'b110000;
    localparam logic [5:0] OP_BZ    = 6'b110001;
    localparam logic [5:0] OP_BN    = 6'b110010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // ALU class is every opcode with op[5] clear
    localparam logic [5:0] ALU_CLASS_MASK = 6'b100000;

    function automatic logic op_is_alu(input logic [5:0] op);
        return (op & ALU_CLASS_MASK) == 6'b000000;
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        return op_is_alu(op) || op == OP_STORE || op == OP_NOP || op == OP_JMPA ||
               op == OP_JMP || op == OP_BZ || op == OP_BN || op == OP_HALT;
    endfunction

    // State entered after DECODE; undefined opcodes behave like NOP
    function automatic state_t decode_dest(input logic [5:0] op);
        state_t nxt;
        nxt = ST_FETCH;
        if (op_is_alu(op))
            nxt = ST_OPER;
        else if (op == OP_STORE)
            nxt = ST_STORE;
        else if (op == OP_JMPA || op == OP_JMP || op == OP_BZ || op == OP_BN)
            nxt = ST_EXEC;
        else if (op == OP_HALT)
            nxt = ST_HALT;
        return nxt;
    endfunction

endpackage

// File: rtl/seq_ctrl.sv
// Multi-cycle fetch/decode/operand/execute sequencer holding IR and PC.
// Memory request lines are registered and held until mem_ack; di_we/acc_we are decoded from state.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [5:0]    op,
    output logic [AW-1:0] field,
    input  logic          acc_update,
    input  logic          br_taken,
    input  logic [DW-1:0] alu_y,
    output logic          di_we,
    output logic          acc_we,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          illegal
);

    localparam logic [AW-1:0] PC_INC = AW'(1);

    state_t        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic          halted_q, halted_d;
    logic          illegal_q, illegal_d;
    logic          xfer;
    logic          req_state;
    logic          unused_alu_hi;

    assign xfer          = mem_req_q && mem_ack;
    assign op            = ir_q[DW-1:AW];
    assign field         = ir_q[AW-1:0];
    assign unused_alu_hi = ^alu_y[DW-1:AW];

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                if (xfer) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + PC_INC;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = decode_dest(op);
                if (!op_is_legal(op)) illegal_d = 1'b1;
            end
            ST_OPER:   if (xfer) state_d = ST_EXEC;
            ST_EXEC: begin
                if (br_taken) pc_d = alu_y[AW-1:0];
                state_d = ST_FETCH;
            end
            ST_STORE:  if (xfer) state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request rises one cycle after entering a bus state and drops right after the handshake
    always_comb begin
        req_state  = (state_q == ST_FETCH) || (state_q == ST_OPER) || (state_q == ST_STORE);
        mem_req_d  = req_state && !xfer;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        if (!mem_req_d) begin
            mem_we_d = 1'b0;
        end else if (!mem_req_q) begin
            mem_we_d   = (state_q == ST_STORE);
            mem_addr_d = (state_q == ST_FETCH) ? pc_q : field;
        end
        halted_d = halted_q || (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            pc_q       <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign pc       = pc_q;
    assign halted   = halted_q;
    assign illegal  = illegal_q;
    assign di_we    = (state_q == ST_OPER) && xfer;
    assign acc_we   = (state_q == ST_EXEC) && acc_update;

endmodule
